// File: rtl/accumulator_mc.sv
// Multi-channel running-sum accumulator with wrap/saturate overflow, sticky
// per-channel overflow flags and a single-entry registered valid/ready readout slot.
module accumulator_mc #(
  parameter int DATA_W   = 8,
  parameter int SUM_W    = 16,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                clear,
  input  logic                rd_req,
  input  logic [CH_W-1:0]     rd_ch,
  input  logic                rd_clear,
  output logic [SUM_W-1:0]    sum,
  output logic [CH_W-1:0]     sum_ch,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic [CHANNELS-1:0] overflow
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t              r_state;
  logic [SUM_W-1:0]    r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic [SUM_W-1:0]    r_sum;
  logic [CH_W-1:0]     r_sumCh;
  logic                r_sumValid;

  logic                w_inHit;
  logic                w_rdHit;
  logic                w_rdAccept;
  logic [SUM_W:0]      w_wide;
  logic [SUM_W-1:0]    w_addVal;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_add;

  assign w_inHit    = 32'(in_ch) < CHANNELS;
  assign w_rdHit    = 32'(rd_ch) < CHANNELS;
  // A held readout blocks new requests unless the consumer takes it this cycle.
  assign w_rdAccept = rd_req && w_rdHit && (r_state == S_IDLE || sum_ready);

  // Only one channel can accumulate per cycle, so a single adder serves them all.
  assign w_wide   = {1'b0, r_acc[in_ch]} + {{(SUM_W + 1 - DATA_W){1'b0}}, data_in};
  assign w_addVal = (w_wide[SUM_W] && SATURATE != 0) ? {SUM_W{1'b1}} : w_wide[SUM_W-1:0];

  always_comb begin
    w_clr = '0;
    w_add = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_clr[c] = (clear && w_inHit && in_ch == CH_W'(c)) ||
                 (w_rdAccept && rd_clear && rd_ch == CH_W'(c));
      w_add[c] = in_valid && w_inHit && in_ch == CH_W'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_clr[c]) begin
          r_acc[c] <= '0;
          r_ovf[c] <= 1'b0;
        end else if (w_add[c]) begin
          r_acc[c] <= w_addVal;
          if (w_wide[SUM_W]) r_ovf[c] <= 1'b1;
        end
      end
    end
  end

  // Readout captures the accumulator value from before this edge's update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sum      <= '0;
      r_sumCh    <= '0;
      r_sumValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rdAccept) begin
            r_sum      <= r_acc[rd_ch];
            r_sumCh    <= rd_ch;
            r_sumValid <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (sum_ready) begin
            if (w_rdAccept) begin
              r_sum   <= r_acc[rd_ch];
              r_sumCh <= rd_ch;
            end else begin
              r_sumValid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sum       = r_sum;
  assign sum_ch    = r_sumCh;
  assign sum_valid = r_sumValid;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_accumulator_mc.sv
// Bench for accumulator_mc: a wrap instance and a saturate instance (SUM_W=10)
// share one stimulus stream and are compared every cycle against an arithmetic model.
module tb_accumulator_mc;

   localparam int SUMW = 10;
   localparam int MAXV = (1 << SUMW) - 1;

   logic            clk;
   logic            rst;
   logic            inValid;
   logic [1:0]      inCh;
   logic [7:0]      dataIn;
   logic            clear;
   logic            rdReq;
   logic [1:0]      rdCh;
   logic            rdClear;
   logic            sumReady;

   logic [SUMW-1:0] sumW, sumS;
   logic [1:0]      sumChW, sumChS;
   logic            sumValidW, sumValidS;
   logic [3:0]      ovfW, ovfS;

   int checks;
   int errors;

   // Model state: index 0 is the wrapping instance, index 1 the saturating one.
   int mAcc [2][4];
   bit mOvf [2][4];
   int mSum [2];
   int mCh;
   bit mValid;

   accumulator_mc #(.DATA_W(8), .SUM_W(SUMW), .CHANNELS(4), .SATURATE(0)) dutWrap (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ch(inCh), .data_in(dataIn),
      .clear(clear), .rd_req(rdReq), .rd_ch(rdCh), .rd_clear(rdClear),
      .sum(sumW), .sum_ch(sumChW), .sum_valid(sumValidW), .sum_ready(sumReady),
      .overflow(ovfW)
   );

   accumulator_mc #(.DATA_W(8), .SUM_W(SUMW), .CHANNELS(4), .SATURATE(1)) dutSat (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ch(inCh), .data_in(dataIn),
      .clear(clear), .rd_req(rdReq), .rd_ch(rdCh), .rd_clear(rdClear),
      .sum(sumS), .sum_ch(sumChS), .sum_valid(sumValidS), .sum_ready(sumReady),
      .overflow(ovfS)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advances the model by one rising edge using the inputs currently applied.
   task automatic modelStep();
      bit accept;
      int t;
      if (!rst) begin
         for (int m = 0; m < 2; m++) begin
            mSum[m] = 0;
            for (int c = 0; c < 4; c++) begin
               mAcc[m][c] = 0;
               mOvf[m][c] = 0;
            end
         end
         mCh = 0;
         mValid = 0;
         return;
      end
      accept = rdReq && (!mValid || sumReady);
      if (accept) begin
         for (int m = 0; m < 2; m++) mSum[m] = mAcc[m][rdCh];
         mCh = rdCh;
         mValid = 1;
      end else if (mValid && sumReady) begin
         mValid = 0;
      end
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 4; c++) begin
            if ((clear && inCh == c) || (accept && rdClear && rdCh == c)) begin
               mAcc[m][c] = 0;
               mOvf[m][c] = 0;
            end else if (inValid && inCh == c) begin
               t = mAcc[m][c] + dataIn;
               if (t > MAXV) begin
                  mOvf[m][c] = 1;
                  mAcc[m][c] = (m == 1) ? MAXV : t % (MAXV + 1);
               end else begin
                  mAcc[m][c] = t;
               end
            end
         end
      end
   endtask

   function automatic logic [3:0] modelOvf(input int m);
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = mOvf[m][c];
      return v;
   endfunction

   // One clock: model and DUTs update on the rising edge, outputs compared on the falling edge.
   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("wrap_valid", 32'(sumValidW), 32'(mValid));
      checkOutput("sat_valid",  32'(sumValidS), 32'(mValid));
      checkOutput("wrap_ch",    32'(sumChW),    32'(mCh));
      checkOutput("sat_ch",     32'(sumChS),    32'(mCh));
      checkOutput("wrap_sum",   32'(sumW),      32'(mSum[0]));
      checkOutput("sat_sum",    32'(sumS),      32'(mSum[1]));
      checkOutput("wrap_ovf",   32'(ovfW),      32'(modelOvf(0)));
      checkOutput("sat_ovf",    32'(ovfS),      32'(modelOvf(1)));
   endtask

   task automatic idleInputs();
      rst = 1'b1; inValid = 1'b0; inCh = 2'd0; dataIn = 8'd0; clear = 1'b0;
      rdReq = 1'b0; rdCh = 2'd0; rdClear = 1'b0; sumReady = 1'b1;
   endtask

   task automatic accum(input logic [1:0] ch, input logic [7:0] d);
      idleInputs();
      inValid = 1'b1; inCh = ch; dataIn = d;
      applyStimulus();
   endtask

   task automatic readCh(input logic [1:0] ch);
      idleInputs();
      rdReq = 1'b1; rdCh = ch;
      applyStimulus();
      idleInputs();
   endtask

   task automatic clearCh(input logic [1:0] ch);
      idleInputs();
      clear = 1'b1; inCh = ch;
      applyStimulus();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idleInputs();
      @(negedge clk);

      rst = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_valid", 32'(sumValidW), 32'd0);
      checkOutput("reset_ovf", 32'(ovfS), 32'd0);
      idleInputs();

      accum(2'd1, 8'd10);
      accum(2'd1, 8'd20);
      accum(2'd1, 8'd30);
      readCh(2'd1);
      checkOutput("ch1_sum60", 32'(sumW), 32'd60);
      checkOutput("ch1_tag", 32'(sumChW), 32'd1);
      checkOutput("ch1_noovf", 32'(ovfW), 32'd0);
      readCh(2'd0);
      checkOutput("ch0_zero", 32'(sumW), 32'd0);

      for (int i = 0; i < 5; i++) accum(2'd2, 8'd255);
      readCh(2'd2);
      checkOutput("wrap_251", 32'(sumW), 32'd251);
      checkOutput("wrap_ovf2", 32'(ovfW[2]), 32'd1);
      checkOutput("sat_1023_ch2", 32'(sumS), 32'd1023);
      clearCh(2'd2);
      checkOutput("clear_ovf2", 32'(ovfW[2]), 32'd0);
      readCh(2'd2);
      checkOutput("clear_read0", 32'(sumW), 32'd0);

      for (int i = 0; i < 5; i++) accum(2'd3, 8'd255);
      accum(2'd3, 8'd5);
      readCh(2'd3);
      checkOutput("sat_hold1023", 32'(sumS), 32'd1023);
      checkOutput("sat_ovf3", 32'(ovfS[3]), 32'd1);
      checkOutput("wrap_256", 32'(sumW), 32'd256);

      clearCh(2'd0);
      accum(2'd0, 8'd40);
      idleInputs();
      inValid = 1'b1; inCh = 2'd0; dataIn = 8'd7;
      rdReq = 1'b1; rdCh = 2'd0; rdClear = 1'b1;
      applyStimulus();
      checkOutput("rdclr_40", 32'(sumW), 32'd40);
      readCh(2'd0);
      checkOutput("rdclr_then0", 32'(sumW), 32'd0);

      accum(2'd1, 8'd3);
      idleInputs();
      clear = 1'b1; inValid = 1'b1; inCh = 2'd1; dataIn = 8'd99;
      applyStimulus();
      readCh(2'd1);
      checkOutput("clr_beats_add", 32'(sumW), 32'd0);

      accum(2'd0, 8'd5);
      accum(2'd1, 8'd9);
      idleInputs();
      sumReady = 1'b0; rdReq = 1'b1; rdCh = 2'd0;
      applyStimulus();
      for (int i = 0; i < 4; i++) begin
         rdReq = (i % 2 == 0); rdCh = 2'd1;
         applyStimulus();
         checkOutput("bp_sum5", 32'(sumW), 32'd5);
         checkOutput("bp_ch0", 32'(sumChW), 32'd0);
      end
      sumReady = 1'b1; rdReq = 1'b1; rdCh = 2'd1;
      applyStimulus();
      checkOutput("b2b_sum9", 32'(sumW), 32'd9);
      checkOutput("b2b_valid", 32'(sumValidW), 32'd1);
      idleInputs();

      accum(2'd2, 8'd77);
      idleInputs();
      sumReady = 1'b0; rdReq = 1'b1; rdCh = 2'd2;
      applyStimulus();
      rdReq = 1'b0; rst = 1'b0;
      applyStimulus();
      checkOutput("midrst_valid", 32'(sumValidW), 32'd0);
      checkOutput("midrst_sum", 32'(sumW), 32'd0);
      checkOutput("midrst_ovf", 32'(ovfS), 32'd0);
      for (int c = 0; c < 4; c++) begin
         readCh(2'(c));
         checkOutput("midrst_chan0", 32'(sumS), 32'd0);
      end

      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 59) != 0);
         inValid  = ($urandom_range(0, 3) != 0);
         inCh     = 2'($urandom_range(0, 3));
         dataIn   = 8'($urandom_range(0, 255));
         clear    = ($urandom_range(0, 11) == 0);
         rdReq    = ($urandom_range(0, 2) == 0);
         rdCh     = 2'($urandom_range(0, 3));
         rdClear  = ($urandom_range(0, 3) == 0);
         sumReady = ($urandom_range(0, 2) != 0);
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/accumulator_mc.md
# accumulator_mc

Parametrised multi-channel accumulator, the successor to the single-channel accumulator. It keeps CHANNELS independent running sums and selects one per cycle by channel index. It offers wrap or saturate overflow modes, sticky per-channel overflow flags and per-channel clear. Results are read out through a registered valid/ready port. It sits between a sample source and a downstream consumer that reads totals on demand.

## Interface
- DATA_W, 8, input sample width (unsigned)
- SUM_W, 16, accumulator width per channel; must be ≥ DATA_W
- CHANNELS, 4, number of independent accumulators; must be ≥ 2
- SATURATE, 0, 0 = modulo 2^SUM_W wrap; 1 = clamp at 2^SUM_W−1
- CH_W, $clog2(CHANNELS), derived channel-index width; not overridden
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  accumulate data_in into channel in_ch this cycle
- in_ch  in  CH_W  target channel for in_valid / clear
- data_in  in  DATA_W  sample
- clear  in  1  zero accumulator and overflow flag of channel in_ch
- rd_req  in  1  request readout of channel rd_ch
- rd_ch  in  CH_W  channel to read
- rd_clear  in  1  with an accepted rd_req, also clear channel rd_ch
- sum  out  SUM_W  readout value
- sum_ch  out  CH_W  channel the readout value belongs to
- sum_valid  out  1  sum/sum_ch valid
- sum_ready  in  1  consumer accepts readout
- overflow  out  CHANNELS  sticky overflow flag, one bit per channel

## Operation
- Reset (rst=0 at a rising edge): all accumulators 0, overflow 0, sum 0, sum_ch 0, sum_valid 0. Reset overrides every other input, including in the middle of a pending readout; the pending readout is dropped.
- Accumulate: when in_valid=1, acc[in_ch] <= acc[in_ch] + data_in, with data_in zero-extended to SUM_W+1 bits.
- Overflow when the true sum > 2^SUM_W−1:
  - SATURATE=0: store the low SUM_W bits.
  - SATURATE=1: store 2^SUM_W−1; an already-saturated channel stays there.
  - Both modes: set overflow[in_ch], which stays 1 until the channel is cleared or reset.
- in_ch or rd_ch ≥ CHANNELS: the operation is ignored (no state change, no readout).
- Clear: when clear=1, acc[in_ch] <= 0 and overflow[in_ch] <= 0. Clear beats in_valid on the same channel in the same cycle; data_in is discarded.
- Readout slot, single entry, states IDLE / HOLD:
  - IDLE, rd_req=1: capture sum <= acc[rd_ch] (the pre-update value, ignoring any same-cycle accumulate or clear), sum_ch <= rd_ch, sum_valid <= 1, go to HOLD.
  - HOLD: sum, sum_ch and sum_valid are stable until sum_valid & sum_ready at a rising edge.
  - HOLD, sum_ready=1: the slot frees. If rd_req=1 in that same cycle, capture the new request (back-to-back reads, stay in HOLD). Otherwise sum_valid <= 0 and go to IDLE.
  - HOLD, sum_ready=0: rd_req is ignored and not queued.
- rd_clear: applies only when rd_req is accepted. It clears acc[rd_ch] and overflow[rd_ch] after capture. If in_valid targets the same channel that cycle, that sample is discarded.
- Accumulate and clear on a channel different from rd_ch proceed independently in the same cycle.

## Timing
- Accumulate latency: 1 cycle. A sample presented at edge N is visible in acc at edge N+1.
- Readout latency: rd_req accepted at edge N → sum_valid=1 from just after edge N, carrying the value acc held before edge N.
- Readout throughput: one readout per cycle while sum_ready is held at 1.
- overflow: updates at the same edge as the accumulate that caused it.
- Outputs: all registered; no combinational path from inputs to outputs.

## Test plan
- Reset then three accumulates of 10, 20, 30 on ch1, read ch1 → sum=60, sum_ch=1, overflow=0000, other channels read 0.
- SUM_W=10, SATURATE=0: five accumulates of 255 on ch2 → read sum=251, overflow[2]=1. Then clear on ch2 → overflow[2]=0 and a read returns 0.
- SUM_W=10, SATURATE=1: five accumulates of 255 on ch3 → sum=1023, overflow[3]=1. One more accumulate of 5 → sum still 1023.
- Same-cycle operations:
  - ch0 holds 40; in_valid with data_in=7 on ch0 plus rd_req ch0 with rd_clear=1 → readout 40, next read 0.
  - clear plus in_valid on ch1 → ch1 reads 0.
- Backpressure: read ch0 (value 5) with sum_ready=0 for 4 cycles while rd_req for ch1 is pulsed → sum stays 5/ch0 and the ch1 request is dropped. Then sum_ready=1 together with rd_req ch1 → next cycle sum=ch1 value, sum_valid stays 1.
- Reset mid-operation: rst=0 for one edge while in HOLD, with channels non-zero → sum_valid=0, sum=0, every channel reads 0, overflow=0000.
